// File: rtl/audio_sd_dac_multi.sv
// N-channel audio output stage: frame FIFO, sample-rate tick generator and one
// first-order sigma-delta modulator per channel driving a 1-bit output pin.
module audio_sd_dac_multi #(
  parameter int CHANNELS        = 2,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int FIFO_DEPTH      = 16,
  parameter int CLKS_PER_SAMPLE = 1134,
  parameter bit SIGNED          = 1'b1
) (
  input  logic                                sys_clock,
  input  logic                                reset_,
  input  logic                                enable,
  input  logic                                sample_valid,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0]    sample_data,
  output logic                                sample_ready,
  output logic                                fifo_full,
  output logic                                fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
  output logic                                underrun,
  input  logic                                underrun_clear,
  output logic                                sample_tick,
  output logic [CHANNELS-1:0]                 audio_out
);

  localparam int W  = SAMPLE_WIDTH;
  localparam int FW = CHANNELS * SAMPLE_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_SAMPLE > 2) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [AW:0]   LEVEL_MAX = (AW + 1)'(FIFO_DEPTH);
  localparam logic [W-1:0]  MIDSCALE  = {1'b1, {(W - 1){1'b0}}};

  // Handshake: a frame transfers on any rising edge where sample_valid and
  // sample_ready are both high; sample_valid while full is simply not taken.

  logic [FW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tick_q, tick_d;
  logic            underrun_q, underrun_d;
  logic [W-1:0]    hold_q [CHANNELS];
  logic [W-1:0]    hold_d [CHANNELS];
  logic [W-1:0]    acc_q  [CHANNELS];
  logic [W-1:0]    acc_d  [CHANNELS];
  logic [W:0]      mod_sum [CHANNELS];
  logic [CHANNELS-1:0] out_q, out_d;
  logic [FW-1:0]   head;
  logic            push, pop, full_w, empty_w;

  assign full_w  = (level_q == LEVEL_MAX);
  assign empty_w = (level_q == '0);
  assign push    = sample_valid && !full_w;
  assign pop     = tick_q && !empty_w;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + (AW + 1)'(1);
    else if (!push && pop) level_d = level_q - (AW + 1)'(1);
  end

  // The counter only runs while enabled; the tick is the registered wrap.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    underrun_d = underrun_q;
    if (underrun_clear)     underrun_d = 1'b0;
    if (tick_q && empty_w)  underrun_d = 1'b1;
  end

  // Hold registers present offset-binary codes to the modulators.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      hold_d[k] = hold_q[k];
      if (pop) begin
        hold_d[k] = head[k*W +: W];
        if (SIGNED) hold_d[k][W-1] = ~head[k*W + W - 1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      mod_sum[k] = {1'b0, acc_q[k]} + {1'b0, hold_q[k]};
      if (enable) begin
        acc_d[k] = mod_sum[k][W-1:0];
        out_d[k] = mod_sum[k][W];
      end else begin
        acc_d[k] = '0;
        out_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clock) begin
    if (push) mem_q[wr_ptr_q] <= sample_data;
  end

  always_ff @(posedge sys_clock) begin
    if (!reset_) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
      out_q      <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        hold_q[k] <= MIDSCALE;
        acc_q[k]  <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      underrun_q <= underrun_d;
      out_q      <= out_d;
      for (int k = 0; k < CHANNELS; k++) begin
        hold_q[k] <= hold_d[k];
        acc_q[k]  <= acc_d[k];
      end
    end
  end

  assign fifo_full    = full_w;
  assign fifo_empty   = empty_w;
  assign sample_ready = !full_w;
  assign fifo_level   = level_q;
  assign underrun     = underrun_q;
  assign sample_tick  = tick_q;
  assign audio_out    = out_q;

endmodule

// File: tb/tb_audio_sd_dac_multi.sv
// Bench for audio_sd_dac_multi: unsigned and signed instances share stimulus;
// each sample tick is compared against an expected observation queue.
module tb_audio_sd_dac_multi;

  localparam int CH    = 2;
  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int CPS   = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int OBS_W = 38;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_;
  logic              enable;
  logic              sample_valid;
  logic [CH*W-1:0]   sample_data;
  logic              underrun_clear;

  logic              ready_u, full_u, empty_u, ur_u, tick_u;
  logic [LW-1:0]     level_u;
  logic [CH-1:0]     out_u;
  logic              ready_s, full_s, empty_s, ur_s, tick_s;
  logic [LW-1:0]     level_s;
  logic [CH-1:0]     out_s;

  audio_sd_dac_multi #(
    .CHANNELS(CH), .SAMPLE_WIDTH(W), .FIFO_DEPTH(DEPTH),
    .CLKS_PER_SAMPLE(CPS), .SIGNED(1'b0)
  ) dut_u (
    .sys_clock(clk), .reset_(reset_), .enable(enable),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ready(ready_u), .fifo_full(full_u), .fifo_empty(empty_u),
    .fifo_level(level_u), .underrun(ur_u), .underrun_clear(underrun_clear),
    .sample_tick(tick_u), .audio_out(out_u)
  );

  audio_sd_dac_multi #(
    .CHANNELS(CH), .SAMPLE_WIDTH(W), .FIFO_DEPTH(DEPTH),
    .CLKS_PER_SAMPLE(CPS), .SIGNED(1'b1)
  ) dut_s (
    .sys_clock(clk), .reset_(reset_), .enable(enable),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ready(ready_s), .fifo_full(full_s), .fifo_empty(empty_s),
    .fifo_level(level_s), .underrun(ur_s), .underrun_clear(underrun_clear),
    .sample_tick(tick_s), .audio_out(out_s)
  );

  // Enabled-cycle counter: value k at a negedge means k enabled edges so far.
  int en_cnt = 0;
  always @(posedge clk) en_cnt <= enable ? en_cnt + 1 : 0;

  // Observation: {dens_valid, en[8], tick_after, ur_u, ur_s, lvl_u, lvl_s,
  //               ones u0, u1, s0, s1 (5 bits each)}
  logic [OBS_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [OBS_W-1:0] act,
                       input logic [OBS_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int en, input bit ur, input int lvl, input bit v,
                          input int u0, input int u1, input int s0, input int s1);
    exp_q.push_back({v, 8'(en), 1'b0, ur, ur, 3'(lvl), 3'(lvl),
                     5'(u0), 5'(u1), 5'(s0), 5'(s1)});
  endtask

  task automatic monitor();
    logic [15:0] h0u = '0, h1u = '0, h0s = '0, h1s = '0;
    bit prev_tick = 1'b0;
    int tick_en = 0;
    logic [OBS_W-1:0] a, e;
    forever begin
      @(negedge clk);
      h0u = {h0u[14:0], out_u[0]};
      h1u = {h1u[14:0], out_u[1]};
      h0s = {h0s[14:0], out_s[0]};
      h1s = {h1s[14:0], out_s[1]};
      if (tick_u || tick_s)
        check("tick_align", OBS_W'(tick_s), OBS_W'(tick_u));
      if (prev_tick) begin
        a = {1'b0, 8'(tick_en), tick_u, ur_u, ur_s, level_u, level_s,
             5'($countones(h0u)), 5'($countones(h1u)),
             5'($countones(h0s)), 5'($countones(h1s))};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tick: got obs %h expected no tick", a);
        end else begin
          e = exp_q.pop_front();
          a[OBS_W-1] = e[OBS_W-1];
          if (!e[OBS_W-1]) begin
            a[19:0] = '0;
            e[19:0] = '0;
          end
          check("tick_obs", a, e);
        end
      end
      prev_tick = tick_u;
      if (tick_u) tick_en = en_cnt;
    end
  endtask

  task automatic wait_en(input int target);
    int guard = 0;
    while (en_cnt != target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_en: got en_cnt %0d expected %0d", en_cnt, target);
    end
  endtask

  task automatic push_frame(input logic [CH*W-1:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  logic [CH*W-1:0] fill_f [5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Frames packed {ch1, ch0}; the fifth is offered while full.
    fill_f = '{8'h21, 8'h43, 8'h96, 8'h3A, 8'h55};
    reset_ = 1'b0; enable = 1'b0; sample_valid = 1'b1;
    sample_data = 8'hFF; underrun_clear = 1'b0;
    fork monitor(); join_none
    repeat (2) @(negedge clk);
    check("rst_level",  OBS_W'({level_u, level_s}), OBS_W'(0));
    check("rst_flags",  OBS_W'({ready_u, empty_u, full_u, ur_u, tick_u}), OBS_W'(5'b11000));
    check("rst_flags_s", OBS_W'({ready_s, empty_s, full_s, ur_s, tick_s}), OBS_W'(5'b11000));
    check("rst_audio",  OBS_W'({out_u, out_s}), OBS_W'(0));
    reset_ = 1'b1; sample_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      push_frame(fill_f[i]);
      check("fill_level", OBS_W'(level_u), OBS_W'((i < DEPTH) ? i + 1 : DEPTH));
      check("fill_full_ready", OBS_W'({full_u, ready_u}),
            OBS_W'((i >= DEPTH - 1) ? 2'b10 : 2'b01));
    end

    // First run, dropped at enabled cycle 12: one pop of frame A.
    push_exp(8, 1'b0, 3, 1'b0, 0, 0, 0, 0);
    enable = 1'b1;
    wait_en(12);
    enable = 1'b0;
    @(negedge clk);
    check("disable_audio", OBS_W'({out_u, out_s, tick_u}), OBS_W'(0));
    repeat (4) @(negedge clk);

    // Second run: ticks restart at enabled cycle 8.
    push_exp(  8, 1'b0, 2, 1'b0,  0,  0,  0,  0);
    push_exp( 16, 1'b0, 1, 1'b0,  0,  0,  0,  0);
    push_exp( 24, 1'b0, 0, 1'b0,  0,  0,  0,  0);
    push_exp( 32, 1'b1, 0, 1'b0,  0,  0,  0,  0);
    push_exp( 40, 1'b1, 0, 1'b1, 10,  3,  2, 11);
    push_exp( 48, 1'b1, 0, 1'b1, 10,  3,  2, 11);
    push_exp( 56, 1'b1, 1, 1'b1, 10,  3,  2, 11);
    push_exp( 64, 1'b1, 0, 1'b1, 10,  3,  2, 11);
    push_exp( 72, 1'b1, 0, 1'b0,  0,  0,  0,  0);
    push_exp( 80, 1'b1, 0, 1'b1,  4, 15, 12,  7);
    push_exp( 88, 1'b1, 0, 1'b1,  4, 15, 12,  7);
    push_exp( 96, 1'b1, 0, 1'b0,  0,  0,  0,  0);
    push_exp(104, 1'b1, 0, 1'b1,  8,  7,  0, 15);
    push_exp(112, 1'b1, 0, 1'b0,  0,  0,  0,  0);
    push_exp(120, 1'b1, 0, 1'b1,  0,  1,  8,  9);
    enable = 1'b1;

    wait_en(40);
    underrun_clear = 1'b1;
    @(negedge clk);
    underrun_clear = 1'b0;
    wait_en(44);
    underrun_clear = 1'b1;
    @(negedge clk);
    underrun_clear = 1'b0;
    check("quiet_clear", OBS_W'({ur_u, ur_s}), OBS_W'(0));

    wait_en(56);
    push_frame(8'hF4);
    wait_en(82);
    push_frame(8'h78);
    check("push_g_level", OBS_W'(level_u), OBS_W'(1));
    wait_en(98);
    push_frame(8'h10);
    check("push_h_level", OBS_W'(level_s), OBS_W'(1));

    wait_en(122);
    enable = 1'b0;
    @(negedge clk);
    check("end_audio", OBS_W'({out_u, out_s}), OBS_W'(0));
    repeat (20) @(negedge clk);
    check("exp_q_drained", OBS_W'(exp_q.size()), OBS_W'(0));

    push_frame(8'h11);
    check("pre_reset_level", OBS_W'(level_u), OBS_W'(1));
    reset_ = 1'b0;
    @(negedge clk);
    reset_ = 1'b1;
    check("mid_reset", OBS_W'({level_u, empty_u, ur_u}), OBS_W'({3'd0, 1'b1, 1'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sd_dac_multi.md
Name: audio_sd_dac_multi

Overview:
- Parametrised N-channel audio output stage: sample FIFO, sample-rate tick generator, per-channel first-order sigma-delta modulator driving 1-bit pins.
- Generalises the fixed stereo path to arbitrary channel count, sample width, FIFO depth and sample rate.
- Adds signed/unsigned input mode, FIFO level reporting and sticky underrun detection.
- Sits between the sample source (synth/mixer) and the board audio pins.

Parameters:
- CHANNELS, 2, number of audio channels and output pins.
- SAMPLE_WIDTH, 16, bits per channel sample.
- FIFO_DEPTH, 16, frames held in FIFO; power of 2, >= 2.
- CLKS_PER_SAMPLE, 1134, sys_clock cycles per sample period (50 MHz / 44.1 kHz); >= 2.
- SIGNED, 1, 1 = two's-complement input, 0 = unsigned offset-binary input.

Ports:
- sys_clock  in  1  system clock; all logic on rising edge.
- reset_  in  1  synchronous, active-low reset.
- enable  in  1  run tick generator and modulators.
- sample_valid  in  1  frame on sample_data is offered.
- sample_data  in  CHANNELS*SAMPLE_WIDTH  one frame; channel k at bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- sample_ready  out  1  FIFO can accept a frame; equals !fifo_full.
- fifo_full  out  1  FIFO holds FIFO_DEPTH frames.
- fifo_empty  out  1  FIFO holds 0 frames.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently stored.
- underrun  out  1  sticky: a tick found the FIFO empty.
- underrun_clear  in  1  clears underrun.
- sample_tick  out  1  one-cycle pulse at each sample boundary.
- audio_out  out  CHANNELS  1-bit sigma-delta outputs, bit k = channel k.

Behaviour:
- Reset (reset_=0 at an edge): FIFO emptied (fifo_level=0, fifo_empty=1, fifo_full=0, sample_ready=1); underrun=0; sample_tick=0; audio_out=0; tick counter=0; accumulators=0; hold registers=midscale offset value 2^(SAMPLE_WIDTH-1). Reset mid-operation discards all stored frames.
- Write: frame stored when sample_valid && sample_ready at an edge. Offering data while full is ignored, with no error flag.
- Tick generator: counter advances only while enable=1. sample_tick=1 for the one cycle after the counter reaches CLKS_PER_SAMPLE-1; counter then wraps to 0. The first tick is registered CLKS_PER_SAMPLE enabled cycles after enable rises.
- Pop: on a tick cycle, if FIFO not empty, head frame moves into the per-channel hold registers at the next edge. If empty, hold registers keep their values and underrun is set.
- Simultaneous push and pop: level unchanged. No bypass: a push in the same cycle as a tick on an empty FIFO still underruns; the pushed frame is stored.
- underrun: set has priority over underrun_clear in the same cycle.
- Input conversion: SIGNED=1 inverts each sample's MSB at pop (two's complement to offset binary); SIGNED=0 passes the sample unchanged.
- Modulator, per channel, every enabled cycle: acc_next = {1'b0, acc[W-1:0]} + u, where W=SAMPLE_WIDTH and u is the hold value. audio_out[k] is the registered carry acc_next[W].
- Density: starting from acc=0, exactly u ones in any 2^W consecutive enabled cycles.
- enable=0: counter forced to 0, accumulators to 0, audio_out to 0, no ticks. FIFO writes still accepted; hold registers retained.

Test Plan:
- Reset: hold reset_=0 two cycles with sample_valid=1 -> fifo_level=0, sample_ready=1, audio_out=0, underrun=0, no writes taken.
- Fill (FIFO_DEPTH=4, enable=0): push 5 frames back-to-back -> fifo_level 1,2,3,4; fifo_full=1 and sample_ready=0 after the 4th; the 5th frame is dropped; after later pops the 5th is never read.
- Tick cadence (CLKS_PER_SAMPLE=8): raise enable -> sample_tick pulses on enabled cycles 8,16,24 exactly one cycle each; dropping enable at cycle 12 restarts the count.
- Density (SAMPLE_WIDTH=4, SIGNED=0, CHANNELS=2): frame ch0=0x4, ch1=0xF, one tick -> over the next 16 cycles, ch0 gives 4 ones and ch1 gives 15 ones.
- Signed mode (SAMPLE_WIDTH=4, SIGNED=1): ch0=0x8 (-8) -> 0 ones per 16 cycles; ch1=0x7 (+7) -> 15 ones; 0x0 -> 8 ones.
- Underrun: tick with FIFO empty -> underrun=1, output density unchanged. Assert underrun_clear on a later underrunning tick -> stays 1. Clear on a quiet cycle -> 0. Push and tick same cycle on empty FIFO -> underrun=1 and fifo_level=1.
